spi_multi_sched: RTL and testbench

- Round-robin scheduler that shares one multi-slave SPI byte interface between N_SLAVES requesters, one requester per slave select.
- Each requester provides a frame in a show-ahead source FIFO.
- The block grants one requester, copies its frame into the SPI master FIFO with the matching one-hot write strobe, then waits for the reply bytes and drains them back to that requester.
- Timeout, stale-data flush and busy/grant status are included.
- Sits in the sys_clk domain between the command decoders and the SPI multi-slave interface.

---
 rtl/spi_multi_sched.sv | 180 ++++++++++++++++++
 tb/tb_spi_multi_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_multi_sched.sv
// Round-robin scheduler sharing one multi-slave SPI byte interface between N_SLAVES requesters.
// Each grant copies one frame to the SPI master FIFO, then drains the reply back to the owner.
module spi_multi_sched #(
    parameter int N_SLAVES        = 3,
    parameter int BYTES_PER_FRAME = 2,
    parameter int TIMEOUT         = 4095
) (
    input  logic                  sys_clk,
    input  logic                  n_rst,
    input  logic [N_SLAVES-1:0]   req_bus,
    input  logic [8*N_SLAVES-1:0] req_data_bus,
    output logic [N_SLAVES-1:0]   req_rdreq_bus,
    output logic [7:0]            m_din,
    output logic [N_SLAVES-1:0]   m_wrreq_bus,
    input  logic [7:0]            s_dout,
    output logic [N_SLAVES-1:0]   s_rdreq_bus,
    input  logic [N_SLAVES-1:0]   have_msg_bus,
    input  logic [7:0]            len,
    output logic [7:0]            rsp_data,
    output logic [N_SLAVES-1:0]   rsp_valid_bus,
    output logic [N_SLAVES-1:0]   timeout_bus,
    output logic [N_SLAVES-1:0]   grant,
    output logic                  busy
);
    localparam int unsigned    NS        = N_SLAVES;
    localparam int             PW        = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int             BW        = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
    localparam logic [BW-1:0]  LAST_BYTE = BW'(BYTES_PER_FRAME - 1);
    localparam logic [15:0]    TMO       = 16'(TIMEOUT);
    localparam logic [7:0]     FRAME_LEN = 8'(BYTES_PER_FRAME);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FLUSH, ST_LOAD, ST_WAIT, ST_DRAIN, ST_DONE
    } state_t;

    state_t                state;
    logic [PW-1:0]         ptr;
    logic [BW-1:0]         bcnt;
    logic [15:0]           tcnt;
    logic [1:0]            fphase;
    logic [N_SLAVES-1:0]   drain_pipe;

    logic                  found;
    logic [PW-1:0]         pick;
    logic [PW-1:0]         cand;
    int unsigned           arb_idx;
    logic                  fsel_done;
    logic [N_SLAVES-1:0]   flush_sel;
    logic [7:0]            head;

    // Rotating search starting at ptr: first requester at or after ptr wins.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        arb_idx = 0;
        for (int unsigned k = 0; k < NS; k++) begin
            arb_idx = 32'(ptr) + k;
            if (arb_idx >= NS) arb_idx = arb_idx - NS;
            cand = PW'(arb_idx);
            if (!found && req_bus[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        fsel_done = 1'b0;
        flush_sel = '0;
        head      = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (!fsel_done && have_msg_bus[k]) begin
                fsel_done    = 1'b1;
                flush_sel[k] = 1'b1;
            end
            if (grant[k]) head = req_data_bus[8*k +: 8];
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            bcnt          <= '0;
            tcnt          <= '0;
            fphase        <= '0;
            drain_pipe    <= '0;
            req_rdreq_bus <= '0;
            m_din         <= '0;
            m_wrreq_bus   <= '0;
            s_rdreq_bus   <= '0;
            rsp_data      <= '0;
            rsp_valid_bus <= '0;
            timeout_bus   <= '0;
            grant         <= '0;
            busy          <= 1'b0;
        end else begin
            m_wrreq_bus   <= '0;
            timeout_bus   <= '0;
            drain_pipe    <= '0;
            rsp_valid_bus <= drain_pipe;
            if (|drain_pipe) rsp_data <= s_dout;
            case (state)
                ST_IDLE: begin
                    if (|have_msg_bus) begin
                        s_rdreq_bus <= flush_sel;
                        fphase      <= '0;
                        busy        <= 1'b1;
                        state       <= ST_FLUSH;
                    end else if (found) begin
                        grant         <= N_SLAVES'(1) << pick;
                        req_rdreq_bus <= N_SLAVES'(1) << pick;
                        ptr           <= (pick == PW'(N_SLAVES - 1)) ? '0 : pick + PW'(1);
                        bcnt          <= '0;
                        busy          <= 1'b1;
                        state         <= ST_LOAD;
                    end
                end
                ST_FLUSH: begin
                    s_rdreq_bus <= '0;
                    if (fphase == 2'd2) begin
                        if (|have_msg_bus) begin
                            s_rdreq_bus <= flush_sel;
                            fphase      <= '0;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        fphase <= fphase + 2'd1;
                    end
                end
                ST_LOAD: begin
                    m_din       <= head;
                    m_wrreq_bus <= grant;
                    if (bcnt == LAST_BYTE) begin
                        req_rdreq_bus <= '0;
                        tcnt          <= '0;
                        state         <= ST_WAIT;
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                ST_WAIT: begin
                    // Reply readiness is tested before the timeout so a tie resolves to DRAIN.
                    if (|(have_msg_bus & grant) && len >= FRAME_LEN) begin
                        s_rdreq_bus <= grant;
                        bcnt        <= '0;
                        state       <= ST_DRAIN;
                    end else if (tcnt + 16'd1 == TMO) begin
                        timeout_bus <= grant;
                        grant       <= '0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    drain_pipe <= s_rdreq_bus;
                    if (bcnt == LAST_BYTE) begin
                        s_rdreq_bus <= '0;
                        state       <= ST_DONE;
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                ST_DONE: begin
                    if (drain_pipe == '0) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_multi_sched.sv
// Scoreboard bench for spi_multi_sched: behavioural requester FIFOs and slave FIFO,
// directed frames push expectations, an independent monitor pops and compares.
module tb_spi_multi_sched;
    localparam int N  = 3;
    localparam int B  = 2;
    localparam int TO = 20;

    logic           sys_clk = 1'b0;
    logic           n_rst   = 1'b0;
    logic [N-1:0]   req_bus = '0;
    logic [8*N-1:0] req_data_bus = '0;
    logic [N-1:0]   req_rdreq_bus;
    logic [7:0]     m_din;
    logic [N-1:0]   m_wrreq_bus;
    logic [7:0]     s_dout = '0;
    logic [N-1:0]   s_rdreq_bus;
    logic [N-1:0]   have_msg_bus = '0;
    logic [7:0]     len = '0;
    logic [7:0]     rsp_data;
    logic [N-1:0]   rsp_valid_bus;
    logic [N-1:0]   timeout_bus;
    logic [N-1:0]   grant;
    logic           busy;

    spi_multi_sched #(.N_SLAVES(N), .BYTES_PER_FRAME(B), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .n_rst(n_rst), .req_bus(req_bus), .req_data_bus(req_data_bus),
        .req_rdreq_bus(req_rdreq_bus), .m_din(m_din), .m_wrreq_bus(m_wrreq_bus),
        .s_dout(s_dout), .s_rdreq_bus(s_rdreq_bus), .have_msg_bus(have_msg_bus), .len(len),
        .rsp_data(rsp_data), .rsp_valid_bus(rsp_valid_bus), .timeout_bus(timeout_bus),
        .grant(grant), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    logic [7:0]     req_q [N][$];
    logic [7:0]     slv_q [$];
    logic [N+7:0]   exp_wr [$];
    logic [N+7:0]   exp_rsp [$];
    logic [N-1:0]   exp_grant [$];
    logic [N-1:0]   exp_to [$];
    int             flush_cyc [$];

    int checks = 0, errors = 0;
    int mcyc = 0, last_wr = 0, strobe_cnt = 0;
    int slv_owner = 0, rep_delay = 0, cd = 0, wr_cnt = 0;
    logic [7:0]   rep0 = '0, rep1 = '0;
    logic [N-1:0] pend_req = '0, prev_grant = '0;
    logic         pend_s = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Environment model: pops take effect one cycle after the strobe (show-ahead / normal mode).
    always @(negedge sys_clk) begin
        if (!n_rst) begin
            pend_req = '0; pend_s = 1'b0; cd = 0; wr_cnt = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (pend_req[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
            if (pend_s) begin
                if (slv_q.size() > 0) s_dout = slv_q.pop_front();
                else s_dout = 8'hEE;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin slv_q.push_back(rep0); slv_q.push_back(rep1); end
            end
            if (m_wrreq_bus != '0) begin
                wr_cnt++;
                if (wr_cnt == B) begin
                    wr_cnt = 0;
                    for (int i = 0; i < N; i++) if (m_wrreq_bus[i]) slv_owner = i;
                    if (rep_delay > 0) cd = rep_delay;
                end
            end
            pend_req = req_rdreq_bus;
            pend_s   = |s_rdreq_bus;
        end
        for (int i = 0; i < N; i++) begin
            req_bus[i] = (req_q[i].size() >= B);
            req_data_bus[8*i +: 8] = (req_q[i].size() > 0) ? req_q[i][0] : 8'h00;
        end
        have_msg_bus = (slv_q.size() > 0) ? (N'(1) << slv_owner) : '0;
        len = 8'(slv_q.size());
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    always @(negedge sys_clk) begin
        logic [N+7:0] e;
        logic [N-1:0] g;
        mcyc++;
        if (n_rst) begin
            if ((req_rdreq_bus | m_wrreq_bus | s_rdreq_bus | rsp_valid_bus | timeout_bus) != '0)
                strobe_cnt++;
            if ((req_rdreq_bus | m_wrreq_bus | s_rdreq_bus | rsp_valid_bus | timeout_bus | grant) != '0)
                check("onehot", {$countones(req_rdreq_bus) <= 1, $countones(m_wrreq_bus) <= 1,
                      $countones(s_rdreq_bus) <= 1, $countones(rsp_valid_bus) <= 1,
                      $countones(timeout_bus) <= 1, $countones(grant) <= 1}, 6'b111111);
            if (m_wrreq_bus != '0) begin
                last_wr = mcyc;
                if (exp_wr.size() == 0) check("wr_unexpected", 32'(m_wrreq_bus), 0);
                else begin e = exp_wr.pop_front(); check("wr_strobe_data", {m_wrreq_bus, m_din}, e); end
            end
            if (rsp_valid_bus != '0) begin
                if (exp_rsp.size() == 0) check("rsp_unexpected", 32'(rsp_valid_bus), 0);
                else begin e = exp_rsp.pop_front(); check("rsp_strobe_data", {rsp_valid_bus, rsp_data}, e); end
            end
            if (timeout_bus != '0) begin
                if (exp_to.size() == 0) check("timeout_unexpected", 32'(timeout_bus), 0);
                else begin
                    g = exp_to.pop_front();
                    check("timeout_bus", timeout_bus, g);
                    check("timeout_latency", mcyc - last_wr, TO);
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                if (exp_grant.size() == 0) check("grant_unexpected", 32'(grant), 0);
                else begin g = exp_grant.pop_front(); check("grant_seq", grant, g); end
            end
            if (s_rdreq_bus != '0 && grant == '0) flush_cyc.push_back(mcyc);
        end
        prev_grant = grant;
    end

    task automatic add_frame(input int s, input logic [7:0] b0, input logic [7:0] b1, input logic reply);
        exp_grant.push_back(N'(1) << s);
        exp_wr.push_back({N'(1) << s, b0});
        exp_wr.push_back({N'(1) << s, b1});
        if (reply) begin
            exp_rsp.push_back({N'(1) << s, rep0});
            exp_rsp.push_back({N'(1) << s, rep1});
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        logic done;
        n = 0; done = 1'b0;
        while (!done && n < limit) begin
            @(negedge sys_clk);
            n++;
            if (!busy && exp_grant.size() == 0 && exp_wr.size() == 0 && exp_rsp.size() == 0
                && exp_to.size() == 0 && cd == 0) done = 1'b1;
        end
        check({name, "_complete"}, 32'(done), 1);
        check({name, "_grant_idle"}, 32'(grant), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        logic seen;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobes", {req_rdreq_bus, m_wrreq_bus, s_rdreq_bus, rsp_valid_bus, timeout_bus}, 0);
        check("rst_data", {m_din, rsp_data}, 0);
        @(posedge sys_clk); #2 n_rst = 1'b1;

        // Single request on slave 0, reply after 10 cycles
        @(posedge sys_clk); #2;
        rep0 = 8'h11; rep1 = 8'h22; rep_delay = 10;
        req_q[0].push_back(8'hA5); req_q[0].push_back(8'h3C);
        add_frame(0, 8'hA5, 8'h3C, 1'b1);
        wait_idle("single", 300);

        // Reset after the first of two LOAD writes
        @(posedge sys_clk); #2;
        req_q[1].push_back(8'h5A); req_q[1].push_back(8'hC3);
        exp_grant.push_back(3'b010);
        exp_wr.push_back({3'b010, 8'h5A});
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge sys_clk);
            if (m_wrreq_bus != '0) seen = 1'b1;
        end
        check("midframe_write_seen", 32'(seen), 1);
        #1 n_rst = 1'b0;
        #1;
        check("midrst_grant_busy", {grant, busy}, 0);
        check("midrst_strobes", {req_rdreq_bus, m_wrreq_bus, s_rdreq_bus, rsp_valid_bus, timeout_bus}, 0);
        req_q[1].delete(); exp_grant.delete(); exp_wr.delete(); exp_rsp.delete();
        repeat (3) @(posedge sys_clk);
        #2 n_rst = 1'b1;
        sc = strobe_cnt;
        repeat (20) @(negedge sys_clk);
        check("post_rst_idle", {grant, busy}, 0);
        check("post_rst_no_strobes", strobe_cnt - sc, 0);

        // Fairness: all three request for two frames each, then only 0 and 2
        @(posedge sys_clk); #2;
        rep0 = 8'h5C; rep1 = 8'hC5; rep_delay = 10;
        for (int s = 0; s < N; s++)
            for (int j = 0; j < 4; j++) req_q[s].push_back(8'(16*s + j));
        for (int r = 0; r < 6; r++)
            add_frame(r % 3, 8'(16*(r % 3) + 2*(r / 3)), 8'(16*(r % 3) + 2*(r / 3) + 1), 1'b1);
        wait_idle("fair_111", 1000);
        @(posedge sys_clk); #2;
        req_q[0].push_back(8'h70); req_q[0].push_back(8'h71);
        req_q[2].push_back(8'h72); req_q[2].push_back(8'h73);
        add_frame(0, 8'h70, 8'h71, 1'b1);
        add_frame(2, 8'h72, 8'h73, 1'b1);
        wait_idle("fair_101", 400);

        // Timeout on slave 1: no reply
        @(posedge sys_clk); #2;
        rep_delay = 0;
        req_q[1].push_back(8'h81); req_q[1].push_back(8'h82);
        add_frame(1, 8'h81, 8'h82, 1'b0);
        exp_to.push_back(3'b010);
        wait_idle("timeout", 200);

        // Late reply flushed, then slave 2 served normally
        @(posedge sys_clk); #2;
        flush_cyc.delete();
        rep0 = 8'h33; rep1 = 8'h44; rep_delay = 10;
        slv_q.push_back(8'hDE); slv_q.push_back(8'hAD);
        req_q[2].push_back(8'h91); req_q[2].push_back(8'h92);
        add_frame(2, 8'h91, 8'h92, 1'b1);
        wait_idle("flush", 300);
        check("flush_pulses", flush_cyc.size(), 2);
        if (flush_cyc.size() == 2) check("flush_spacing", flush_cyc[1] - flush_cyc[0], 3);

        // Reply readiness coincides with the timeout cycle: DRAIN must win
        @(posedge sys_clk); #2;
        rep0 = 8'h66; rep1 = 8'h77; rep_delay = TO - 1;
        req_q[0].push_back(8'hA1); req_q[0].push_back(8'hA2);
        add_frame(0, 8'hA1, 8'hA2, 1'b1);
        wait_idle("tie", 300);

        repeat (5) @(negedge sys_clk);
        check("scoreboard_empty", exp_wr.size() + exp_rsp.size() + exp_grant.size() + exp_to.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
